// File: rtl/step_watchdog_pkg.sv
// step_watchdog_pkg
//   Shared definitions for the step-activity watchdog:
//   - sw_state_t : FSM state encodings (DISARMED=0, ARMED=1, TRIPPED=2;
//                  encoding 3 is unused and recovers to DISARMED)
//   - SW_TIMEOUT_INIT : default idle timeout, derived from the system clock
//                  rate and the default timeout in seconds
package step_watchdog_pkg;

  typedef enum logic [1:0] {
    SW_DISARMED = 2'd0,
    SW_ARMED    = 2'd1,
    SW_TRIPPED  = 2'd2
  } sw_state_t;

  localparam longint unsigned SW_HZ           = 48_000_000;
  localparam longint unsigned SW_TIMEOUT_SECS = 10;

  function automatic longint unsigned sw_timeout_cycles(input longint unsigned hz,
                                                        input longint unsigned secs);
    return hz * secs;
  endfunction

  localparam longint unsigned SW_TIMEOUT_INIT = sw_timeout_cycles(SW_HZ, SW_TIMEOUT_SECS);

endpackage

// File: rtl/step_watchdog_idle_counter.sv
// step_idle_counter
//   One watched step channel: remembers the previous step level, counts idle
//   clocks since the last step edge (either polarity) and registers an alert
//   once the idle count has reached the timeout.
// Ports
//   clk      in   1         system clock
//   rst      in   1         asynchronous reset, active-high
//   step     in   1         step line, synchronous to clk
//   timeout  in   CNT_BITS  idle limit in clk cycles; 0 disables the alert
//   idle     out  CNT_BITS  current idle count
//   alert    out  1         registered, idle >= timeout (and timeout != 0)
module step_idle_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic [CNT_BITS-1:0] timeout,
  output logic [CNT_BITS-1:0] idle,
  output logic                alert
);

  logic                prev_step_reg;
  logic [CNT_BITS-1:0] idle_reg;
  logic                alert_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_step_reg <= 1'b0;
      idle_reg      <= '0;
      alert_reg     <= 1'b0;
    end else begin
      prev_step_reg <= step;
      // Activity wins; otherwise count up to the timeout and hold there, so the
      // counter never exceeds max(idle, timeout) and cannot wrap.
      if (step != prev_step_reg) begin
        idle_reg <= '0;
      end else if (idle_reg < timeout) begin
        idle_reg <= idle_reg + CNT_BITS'(1);
      end
      // >= rather than == so that lowering the timeout below the current idle
      // count still raises the alert.
      alert_reg <= (timeout != '0) && (idle_reg >= timeout);
    end
  end

  assign idle  = idle_reg;
  assign alert = alert_reg;

endmodule

// File: rtl/step_watchdog.sv
// step_watchdog
//   Per-channel step-activity watchdog. Each of NCH step lines has an idle
//   counter; channels idle for >= timeout clocks raise alert. An arm/disarm/
//   trip FSM turns a masked alert into a sticky trip record and shutdown.
// Ports
//   clk          in   1         system clock
//   rst          in   1         asynchronous reset, active-high
//   step         in   NCH       step lines
//   cfg_wr_en    in   1         load cfg_timeout and cfg_mask
//   cfg_timeout  in   CNT_BITS  timeout in clk cycles; 0 disables the watchdog
//   cfg_mask     in   NCH       channels allowed to trip
//   arm_req      in   1         DISARMED -> ARMED
//   disarm_req   in   1         ARMED -> DISARMED
//   clear        in   1         TRIPPED -> DISARMED
//   alert        out  NCH       registered per-channel idle alert (unmasked)
//   trip_ch      out  NCH       sticky alert&mask captured when tripping
//   shutdown     out  1         high while TRIPPED
//   state        out  2         current FSM state
//   dbg_sel      in   clog2(NCH) channel select for dbg_idle
//   dbg_idle     out  8         top byte of the selected idle counter
module step_watchdog
  import step_watchdog_pkg::*;
#(
  parameter int                NCH          = 6,
  parameter int                CNT_BITS     = 32,
  parameter logic [CNT_BITS-1:0] TIMEOUT_INIT = CNT_BITS'(SW_TIMEOUT_INIT),
  parameter logic [NCH-1:0]    MASK_INIT    = NCH'(6'b100000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           step,
  input  logic                     cfg_wr_en,
  input  logic [CNT_BITS-1:0]      cfg_timeout,
  input  logic [NCH-1:0]           cfg_mask,
  input  logic                     arm_req,
  input  logic                     disarm_req,
  input  logic                     clear,
  output logic [NCH-1:0]           alert,
  output logic [NCH-1:0]           trip_ch,
  output logic                     shutdown,
  output logic [1:0]               state,
  input  logic [$clog2(NCH)-1:0]   dbg_sel,
  output logic [7:0]               dbg_idle
);

  localparam int SEL_N = 2 ** $clog2(NCH);

  logic [CNT_BITS-1:0] timeout_reg;
  logic [NCH-1:0]      mask_reg;
  logic [CNT_BITS-1:0] idle_arr [NCH];
  logic [7:0]          dbg_bytes [SEL_N];

  sw_state_t      state_reg, state_next;
  logic [NCH-1:0] trip_ch_reg, trip_ch_next;
  logic [NCH-1:0] trip_hits;

  // Configuration: takes effect the cycle after the write; counters keep running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_reg <= TIMEOUT_INIT;
      mask_reg    <= MASK_INIT;
    end else if (cfg_wr_en) begin
      timeout_reg <= cfg_timeout;
      mask_reg    <= cfg_mask;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      step_idle_counter #(
        .CNT_BITS (CNT_BITS)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .step    (step[gi]),
        .timeout (timeout_reg),
        .idle    (idle_arr[gi]),
        .alert   (alert[gi])
      );
    end
  endgenerate

  // Trip decision uses the registered alert, so shutdown follows one cycle later.
  assign trip_hits = alert & mask_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= SW_DISARMED;
      trip_ch_reg <= '0;
    end else begin
      state_reg   <= state_next;
      trip_ch_reg <= trip_ch_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    trip_ch_next = trip_ch_reg;
    case (state_reg)
      SW_DISARMED: begin
        if (arm_req) state_next = SW_ARMED;
      end
      SW_ARMED: begin
        // A trip outranks a simultaneous disarm request.
        if (|trip_hits) begin
          state_next   = SW_TRIPPED;
          trip_ch_next = trip_hits;
        end else if (disarm_req) begin
          state_next = SW_DISARMED;
        end
      end
      SW_TRIPPED: begin
        if (clear) begin
          state_next   = SW_DISARMED;
          trip_ch_next = '0;
        end
      end
      default: begin
        state_next   = SW_DISARMED;
        trip_ch_next = '0;
      end
    endcase
  end

  assign state    = state_reg;
  assign trip_ch  = trip_ch_reg;
  assign shutdown = (state_reg == SW_TRIPPED);

  // Debug mux padded to a power of two so out-of-range selects read zero.
  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_dbg
      if (gi < NCH) begin : g_real
        assign dbg_bytes[gi] = idle_arr[gi][CNT_BITS-1 -: 8];
      end else begin : g_pad
        assign dbg_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign dbg_idle = dbg_bytes[dbg_sel];

endmodule

// File: tb/tb_step_watchdog.sv
module tb_step_watchdog;

  localparam int NCH      = 6;
  localparam int CNT_BITS = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NCH-1:0]      step = '0;
  logic                cfg_wr_en = 1'b0;
  logic [CNT_BITS-1:0] cfg_timeout = '0;
  logic [NCH-1:0]      cfg_mask = '0;
  logic                arm_req = 1'b0;
  logic                disarm_req = 1'b0;
  logic                clear = 1'b0;
  logic [NCH-1:0]      alert;
  logic [NCH-1:0]      trip_ch;
  logic                shutdown;
  logic [1:0]          state;
  logic [2:0]          dbg_sel = 3'd0;
  logic [7:0]          dbg_idle;

  step_watchdog #(
    .NCH          (NCH),
    .CNT_BITS     (CNT_BITS),
    .TIMEOUT_INIT (8'd10),
    .MASK_INIT    (6'b100000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_timeout (cfg_timeout),
    .cfg_mask    (cfg_mask),
    .arm_req     (arm_req),
    .disarm_req  (disarm_req),
    .clear       (clear),
    .alert       (alert),
    .trip_ch     (trip_ch),
    .shutdown    (shutdown),
    .state       (state),
    .dbg_sel     (dbg_sel),
    .dbg_idle    (dbg_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int SEL_ALERT = 0, SEL_TRIP = 1, SEL_SHDN = 2, SEL_STATE = 3, SEL_DBG = 4;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] mask;
    logic [7:0] exp_val;
    int         due;
  } sb_t;

  sb_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
    vectors++;
    if (obs !== exp_val) begin
      miscompares++;
      $display("FAIL %-12s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp_val);
    end else begin
      $display("  ok %-12s cyc=%0d value=%0h", tag, cyc, obs);
    end
  endtask

  function automatic logic [7:0] pick(input int sel);
    case (sel)
      SEL_ALERT: return {2'b00, alert};
      SEL_TRIP:  return {2'b00, trip_ch};
      SEL_SHDN:  return {7'b0, shutdown};
      SEL_STATE: return {6'b0, state};
      default:   return dbg_idle;
    endcase
  endfunction

  // Queue an expectation to be checked d clock edges from now.
  task automatic expect_at(input string tag, input int sel, input logic [7:0] mask,
                           input logic [7:0] exp_val, input int d);
    sb_t e;
    e.tag = tag; e.sel = sel; e.mask = mask; e.exp_val = exp_val; e.due = cyc + d;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check_val(sb_q[i].tag, pick(sb_q[i].sel) & sb_q[i].mask, sb_q[i].exp_val & sb_q[i].mask);
        sb_q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    check_val("rst_alert", pick(SEL_ALERT), 8'h00);
    check_val("rst_trip",  pick(SEL_TRIP),  8'h00);
    check_val("rst_shdn",  pick(SEL_SHDN),  8'h00);
    check_val("rst_state", pick(SEL_STATE), 8'h00);
    tick(2);

    // 1: first alert exactly 11 edges after release
    rst = 1'b0;
    expect_at("t1_alert10", SEL_ALERT, 8'h3F, 8'h00, 10);
    expect_at("t1_alert11", SEL_ALERT, 8'h3F, 8'h3F, 11);
    expect_at("t1_state",   SEL_STATE, 8'hFF, 8'h00, 11);
    expect_at("t1_shdn",    SEL_SHDN,  8'hFF, 8'h00, 11);
    tick(12);

    // 2: step[2] toggling every 5 cycles keeps its alert low
    dbg_sel = 3'd2;
    for (int k = 0; k < 20; k++) begin
      step[2] = ~step[2];
      expect_at("t2_alert", SEL_ALERT, 8'h3F, 8'h3B, 2);
      if (k == 10) expect_at("t2_dbg", SEL_DBG, 8'hFF, 8'd4, 5);
      tick(5);
    end

    // 3: armed, step[5] active -> no trip; stop it -> trip
    dbg_sel = 3'd5;
    for (int k = 0; k < 8; k++) begin
      step[5] = ~step[5];
      if (k == 3) begin
        arm_req = 1'b1;
        expect_at("t3_armed", SEL_STATE, 8'hFF, 8'h01, 1);
      end
      if (k >= 2) expect_at("t3_notrip", SEL_SHDN, 8'hFF, 8'h00, 3);
      if (k == 7) begin
        expect_at("t3_alert5lo", SEL_ALERT, 8'h20, 8'h00, 11);
        expect_at("t3_alert5hi", SEL_ALERT, 8'h20, 8'h20, 12);
        expect_at("t3_shdn_lo",  SEL_SHDN,  8'hFF, 8'h00, 12);
        expect_at("t3_shdn_hi",  SEL_SHDN,  8'hFF, 8'h01, 13);
        expect_at("t3_trip_ch",  SEL_TRIP,  8'hFF, 8'h20, 13);
        expect_at("t3_state",    SEL_STATE, 8'hFF, 8'h02, 13);
      end
      tick(1);
      arm_req = 1'b0;
      tick(4);
    end
    tick(10);

    // 4: disarm/arm ignored in TRIPPED; clear returns to DISARMED
    disarm_req = 1'b1;
    arm_req    = 1'b1;
    expect_at("t4_stay", SEL_STATE, 8'hFF, 8'h02, 1);
    expect_at("t4_shdn", SEL_SHDN,  8'hFF, 8'h01, 1);
    tick(1);
    disarm_req = 1'b0;
    arm_req    = 1'b0;
    clear      = 1'b1;
    expect_at("t4_clr_state", SEL_STATE, 8'hFF, 8'h00, 1);
    expect_at("t4_clr_shdn",  SEL_SHDN,  8'hFF, 8'h00, 1);
    expect_at("t4_clr_trip",  SEL_TRIP,  8'hFF, 8'h00, 1);
    tick(1);
    clear = 1'b0;
    tick(1);

    // 5: lower timeout below current idle; then disable
    dbg_sel     = 3'd1;
    step[1]     = ~step[1];
    cfg_wr_en   = 1'b1;
    cfg_timeout = 8'd100;
    cfg_mask    = 6'b100000;
    tick(1);
    cfg_wr_en = 1'b0;
    tick(49);
    cfg_wr_en   = 1'b1;
    cfg_timeout = 8'd5;
    expect_at("t5_dbg49",  SEL_DBG,   8'hFF, 8'd49, 0);
    expect_at("t5_dbg50",  SEL_DBG,   8'hFF, 8'd50, 1);
    expect_at("t5_a1_lo",  SEL_ALERT, 8'h02, 8'h00, 1);
    expect_at("t5_a1_hi",  SEL_ALERT, 8'h02, 8'h02, 2);
    expect_at("t5_hold50", SEL_DBG,   8'hFF, 8'd50, 3);
    tick(1);
    cfg_wr_en = 1'b0;
    tick(3);
    cfg_wr_en   = 1'b1;
    cfg_timeout = 8'd0;
    expect_at("t5_dis_a2",  SEL_ALERT, 8'h3F, 8'h00, 2);
    expect_at("t5_dis_a3",  SEL_ALERT, 8'h3F, 8'h00, 3);
    expect_at("t5_dis_dbg", SEL_DBG,   8'hFF, 8'd50, 3);
    tick(1);
    cfg_wr_en = 1'b0;
    tick(3);

    // 6: trip beats a simultaneous disarm; async reset drops shutdown
    step[5]     = ~step[5];
    cfg_wr_en   = 1'b1;
    cfg_timeout = 8'd10;
    tick(1);
    cfg_wr_en = 1'b0;
    tick(4);
    step[5] = ~step[5];
    arm_req = 1'b1;
    expect_at("t6_armed",   SEL_STATE, 8'hFF, 8'h01, 1);
    expect_at("t6_alert5lo", SEL_ALERT, 8'h20, 8'h00, 11);
    tick(1);
    arm_req = 1'b0;
    tick(11);
    disarm_req = 1'b1;
    expect_at("t6_alert5hi", SEL_ALERT, 8'h20, 8'h20, 0);
    expect_at("t6_state",    SEL_STATE, 8'hFF, 8'h02, 1);
    expect_at("t6_shdn",     SEL_SHDN,  8'hFF, 8'h01, 1);
    expect_at("t6_trip_ch",  SEL_TRIP,  8'hFF, 8'h20, 1);
    tick(1);
    disarm_req = 1'b0;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check_val("t6_rst_shdn",  pick(SEL_SHDN),  8'h00);
    check_val("t6_rst_state", pick(SEL_STATE), 8'h00);
    check_val("t6_rst_trip",  pick(SEL_TRIP),  8'h00);
    check_val("t6_rst_alert", pick(SEL_ALERT), 8'h00);
    tick(2);

    while (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL %-12s never checked (due cyc=%0d, now %0d)", sb_q[0].tag, sb_q[0].due, cyc);
      void'(sb_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
